// File: rtl/local_ni_tx_if.sv
// Core-to-router handshake bundle for the local network-interface transmitter.
// "master" is the core/router side and "slave" is the NI block.
interface local_ni_tx_if #(
    parameter int FLIT_W        = 4,
    parameter int PAYLOAD_FLITS = 4
);
    logic                            pkt_valid;
    logic                            pkt_ready;
    logic [FLIT_W-1:0]               pkt_dest;
    logic [FLIT_W*PAYLOAD_FLITS-1:0] pkt_data;
    logic [FLIT_W-1:0]               local_in;
    logic                            write_local;
    logic                            local_full;
    logic                            busy;
    logic                            pkt_sent;

    modport master (
        output pkt_valid, pkt_dest, pkt_data, local_full,
        input  pkt_ready, local_in, write_local, busy, pkt_sent
    );

    modport slave (
        input  pkt_valid, pkt_dest, pkt_data, local_full,
        output pkt_ready, local_in, write_local, busy, pkt_sent
    );
endinterface

// File: rtl/local_ni_tx.sv
// Local NI transmitter: serialises a captured packet as header + body flits (MS-first).
// Define NI_PARITY_EN to append one XOR parity flit after the body.
module local_ni_tx #(
    parameter int FLIT_W        = 4,
    parameter int PAYLOAD_FLITS = 4
) (
    input  logic          clk,
    input  logic          reset,
    local_ni_tx_if.slave  bus
);
    localparam int DATA_W = FLIT_W * PAYLOAD_FLITS;
    localparam int IDX_W  = (PAYLOAD_FLITS > 1) ? $clog2(PAYLOAD_FLITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_FLITS - 1);

`ifdef NI_PARITY_EN
    typedef enum logic [1:0] {IDLE, HEAD, BODY, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
`endif

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [FLIT_W-1:0]  flit, flit_next;
    logic               sent, sent_next;
    logic [DATA_W-1:0]  data_q;
    logic               accept;
    logic               xfer;

    function automatic logic [FLIT_W-1:0] body_flit(input logic [DATA_W-1:0] d,
                                                    input logic [IDX_W-1:0]  i);
        logic [DATA_W-1:0] s;
        s = d << (int'(i) * FLIT_W);
        return s[DATA_W-1 -: FLIT_W];
    endfunction

`ifdef NI_PARITY_EN
    function automatic logic [FLIT_W-1:0] parity_flit(input logic [DATA_W-1:0] d);
        logic [FLIT_W-1:0] p;
        p = '0;
        for (int k = 0; k < PAYLOAD_FLITS; k++) p ^= d[k*FLIT_W +: FLIT_W];
        return p;
    endfunction
`endif

    assign accept          = (state == IDLE) && bus.pkt_valid;
    assign xfer            = (state != IDLE) && !bus.local_full;
    assign bus.write_local = xfer;
    assign bus.pkt_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.local_in    = flit;
    assign bus.pkt_sent    = sent;

    // Packet capture: payload is frozen at accept so mid-flight input changes are invisible.
    always_ff @(posedge clk) begin
        if (accept) data_q <= bus.pkt_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            flit  <= '0;
            sent  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            flit  <= flit_next;
            sent  <= sent_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        flit_next  = flit;
        sent_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    state_next = HEAD;
                    idx_next   = '0;
                    flit_next  = bus.pkt_dest;
                end
            end
            HEAD: begin
                if (xfer) begin
                    state_next = BODY;
                    idx_next   = '0;
                    flit_next  = body_flit(data_q, '0);
                end
            end
            BODY: begin
                if (xfer) begin
                    if (idx != LAST_IDX) begin
                        idx_next  = idx + IDX_W'(1);
                        flit_next = body_flit(data_q, idx + IDX_W'(1));
                    end else begin
`ifdef NI_PARITY_EN
                        state_next = PAR;
                        flit_next  = parity_flit(data_q);
`else
                        state_next = IDLE;
                        sent_next  = 1'b1;
`endif
                    end
                end
            end
`ifdef NI_PARITY_EN
            PAR: begin
                if (xfer) begin
                    state_next = IDLE;
                    sent_next  = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_local_ni_tx.sv
// Directed bench for local_ni_tx: reset, plain packets, back-pressure, back-to-back, mid-packet reset.
module tb_local_ni_tx;
    localparam int FLIT_W        = 4;
    localparam int PAYLOAD_FLITS = 4;
`ifdef NI_PARITY_EN
    localparam int NF = 6;
`else
    localparam int NF = 5;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   wr_cnt;

    local_ni_tx_if #(.FLIT_W(FLIT_W), .PAYLOAD_FLITS(PAYLOAD_FLITS)) bus ();

    local_ni_tx #(.FLIT_W(FLIT_W), .PAYLOAD_FLITS(PAYLOAD_FLITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.write_local) wr_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Entry: just after a rising edge with the block idle. Exit: just after the last transfer edge.
    task automatic send_packet(input string name, input logic [3:0] dest, input logic [15:0] data,
                               input logic [3:0] flits [6], input int stall_flit,
                               input int stall_len, input logic exp_sent);
        bus.pkt_valid = 1'b1;
        bus.pkt_dest  = dest;
        bus.pkt_data  = data;
        @(negedge clk);
        check_eq({name, " idle_ready"}, bus.pkt_ready, 1'b1);
        check_eq({name, " prev_sent"}, bus.pkt_sent, exp_sent);
        @(posedge clk); #1;
        bus.pkt_valid = 1'b0;
        bus.pkt_dest  = 4'h0;
        bus.pkt_data  = 16'hFFFF;
        for (int k = 0; k < NF; k++) begin
            if (k == stall_flit) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.local_full = 1'b1;
                    @(negedge clk);
                    check_eq($sformatf("%s stall%0d_wr", name, s), bus.write_local, 1'b0);
                    check_eq($sformatf("%s stall%0d_flit", name, s), bus.local_in, flits[k]);
                    check_eq($sformatf("%s stall%0d_busy", name, s), bus.busy, 1'b1);
                    @(posedge clk); #1;
                end
                bus.local_full = 1'b0;
            end
            @(negedge clk);
            check_eq($sformatf("%s flit%0d_wr", name, k), bus.write_local, 1'b1);
            check_eq($sformatf("%s flit%0d", name, k), bus.local_in, flits[k]);
            check_eq($sformatf("%s flit%0d_ready", name, k), bus.pkt_ready, 1'b0);
            check_eq($sformatf("%s flit%0d_sent", name, k), bus.pkt_sent, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_packet(input string name);
        @(negedge clk);
        check_eq({name, " sent_pulse"}, bus.pkt_sent, 1'b1);
        check_eq({name, " ready_back"}, bus.pkt_ready, 1'b1);
        check_eq({name, " wr_idle"}, bus.write_local, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq({name, " sent_once"}, bus.pkt_sent, 1'b0);
        check_eq({name, " still_idle"}, bus.busy, 1'b0);
        @(posedge clk); #1;
    endtask

    logic [3:0] pk_a [6];
    logic [3:0] pk_b [6];
    logic [3:0] pk_c [6];
    logic [3:0] pk_d [6];
    int         wr_before;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wr_cnt  = 0;
        pk_a = '{4'h5, 4'h6, 4'hB, 4'hC, 4'hE, 4'hF};
        pk_b = '{4'h3, 4'h4, 4'h7, 4'h8, 4'hC, 4'h7};
        pk_c = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hE, 4'h2};
        pk_d = '{4'h9, 4'h1, 4'h2, 4'h3, 4'h4, 4'h4};

        // Reset held with a packet offered: nothing may be accepted or written.
        reset          = 1'b1;
        bus.pkt_valid  = 1'b1;
        bus.pkt_dest   = 4'h5;
        bus.pkt_data   = 16'h6BCE;
        bus.local_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst%0d_wr", c), bus.write_local, 1'b0);
            check_eq($sformatf("rst%0d_flit", c), bus.local_in, 4'h0);
            check_eq($sformatf("rst%0d_ready", c), bus.pkt_ready, 1'b1);
            check_eq($sformatf("rst%0d_busy", c), bus.busy, 1'b0);
            check_eq($sformatf("rst%0d_sent", c), bus.pkt_sent, 1'b0);
        end
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.pkt_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", bus.pkt_ready, 1'b1);
        @(posedge clk); #1;

        // Plain packet, payload input scrambled after accept.
        send_packet("pktA", 4'h5, 16'h6BCE, pk_a, -1, 0, 1'b0);
        finish_packet("pktA");

        // Same packet with three full cycles while flit B sits on the port.
        send_packet("stallB", 4'h5, 16'h6BCE, pk_a, 2, 3, 1'b0);
        finish_packet("stallB");

        // Back-to-back: second packet offered in the single idle cycle after the first.
        send_packet("b2b1", 4'h3, 16'h478C, pk_b, -1, 0, 1'b0);
        send_packet("b2b2", 4'hC, 16'hDEFE, pk_c, -1, 0, 1'b1);
        finish_packet("b2b2");

        // Reset after header and two body flits have transferred.
        bus.pkt_valid = 1'b1;
        bus.pkt_dest  = 4'h5;
        bus.pkt_data  = 16'h6BCE;
        @(posedge clk); #1;
        bus.pkt_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("pre_rst_wr", bus.write_local, 1'b1);
        check_eq("pre_rst_flit", bus.local_in, 4'hC);
        reset = 1'b1;
        #1;
        check_eq("rst_now_wr", bus.write_local, 1'b0);
        check_eq("rst_now_flit", bus.local_in, 4'h0);
        check_eq("rst_now_ready", bus.pkt_ready, 1'b1);
        check_eq("rst_now_busy", bus.busy, 1'b0);
        wr_before = wr_cnt;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("rst_no_writes", wr_cnt, wr_before);
        check_eq("rst_no_sent", bus.pkt_sent, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        send_packet("after_rst", 4'h9, 16'h1234, pk_d, -1, 0, 1'b0);
        finish_packet("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
